// File: rtl/shift_right_iter.sv
// Iterative 16-bit right shifter/rotator (SRL, SRA, ROR) with start/done handshake.
// Retires up to 4 bit positions per cycle; latency 1 to 7 cycles after start.
module shift_right_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Ain,
    input  logic [4:0]  shamt,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] Aout
);

    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [15:0] work;
    logic [4:0]  cnt;
    logic [1:0]  mode_r;

    logic [4:0]  cnt_in;
    logic        step4;
    logic [3:0]  fill4;
    logic        fill1;
    logic [15:0] work_nx;
    logic [4:0]  cnt_nx;

    // Shifts clamp at 16 (everything shifted out); rotates wrap modulo 16.
    always_comb begin
        cnt_in = {1'b0, shamt[3:0]};
        if (mode != MODE_ROR && shamt[4])
            cnt_in = 5'd16;
    end

    always_comb begin
        fill4 = 4'b0000;
        fill1 = 1'b0;
        if (mode_r == MODE_ROR) begin
            fill4 = work[3:0];
            fill1 = work[0];
        end else if (mode_r == MODE_SRA) begin
            fill4 = {4{work[15]}};
            fill1 = work[15];
        end
    end

    always_comb begin
        step4   = (cnt >= 5'd4);
        work_nx = {fill1, work[15:1]};
        cnt_nx  = cnt - 5'd1;
        if (step4) begin
            work_nx = {fill4, work[15:4]};
            cnt_nx  = cnt - 5'd4;
        end
    end

    // Aout is loaded on the edge that enters DONE, so it is valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            work   <= 16'h0000;
            cnt    <= 5'd0;
            mode_r <= 2'b00;
            Aout   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= Ain;
                        cnt    <= cnt_in;
                        mode_r <= mode;
                        if (cnt_in == 5'd0) begin
                            Aout  <= Ain;
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_nx;
                    cnt  <= cnt_nx;
                    if (cnt_nx == 5'd0) begin
                        Aout  <= work_nx;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_right_iter.sv
// Randomized scoreboard bench for shift_right_iter: driver pushes expected result
// and done cycle, monitor pops and compares whenever done is seen.
module tb_shift_right_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic [15:0] Ain;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [15:0] Aout;

    logic [15:0] exp_q[$];
    int          exp_t_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] last_aout = 16'h0000;
    bit          finished = 1'b0;

    shift_right_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ain   (Ain),
        .shamt (shamt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .Aout  (Aout)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model
    function automatic logic [15:0] ref_result(input logic [1:0] m, input logic [15:0] a,
                                               input logic [4:0] s);
        logic [31:0] d;
        int k;
        case (m)
            2'b01: begin
                if (s >= 5'd16) return {16{a[15]}};
                return 16'($signed(a) >>> s);
            end
            2'b10: begin
                k = int'(s) % 16;
                d = {a, a} >> k;
                return d[15:0];
            end
            default: begin
                if (s >= 5'd16) return 16'h0000;
                return a >> s;
            end
        endcase
    endfunction

    function automatic int ref_cycles(input logic [1:0] m, input logic [4:0] s);
        int c;
        if (m == 2'b10) c = int'(s) % 16;
        else c = (int'(s) > 16) ? 16 : int'(s);
        return c / 4 + c % 4;
    endfunction

    // driver tasks
    task automatic issue(input logic [1:0] m, input logic [15:0] a, input logic [4:0] s,
                         input bit junk);
        int t;
        int n;
        Ain = a; shamt = s; mode = m; start = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        n = ref_cycles(m, s);
        exp_q.push_back(ref_result(m, a, s));
        exp_t_q.push_back(t + n);
        start = 1'b0;
        while (cyc <= t + n) begin
            if (junk) begin
                Ain   = 16'($urandom);
                shamt = 5'($urandom);
                mode  = 2'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_done", {31'b0, done}, 32'd0);
                chk("rst_aout", {16'b0, Aout}, 32'd0);
                exp_q.delete();
                exp_t_q.delete();
                last_aout = 16'h0000;
            end else if (finished) begin
                chk("queue_empty", exp_q.size(), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end else begin
                if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
                    chk("missing_done", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                end
                chk("busy", {31'b0, busy}, {31'b0, (exp_q.size() > 0)});
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        chk("aout", {16'b0, Aout}, {16'b0, exp_q[0]});
                        chk("done_cycle", cyc, exp_t_q[0]);
                        last_aout = exp_q[0];
                        void'(exp_q.pop_front());
                        void'(exp_t_q.pop_front());
                    end
                end else begin
                    chk("aout_hold", {16'b0, Aout}, {16'b0, last_aout});
                end
            end
        end
    end

    // stimulus
    initial begin
        int t;
        start = 1'b0; Ain = 16'h0000; shamt = 5'd0; mode = 2'b00;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(2'b00, 16'h8001, 5'd1, 1'b0);
        issue(2'b01, 16'h8000, 5'd15, 1'b0);
        issue(2'b01, 16'h8000, 5'd31, 1'b0);
        issue(2'b01, 16'h7FFF, 5'd31, 1'b0);
        issue(2'b10, 16'h1234, 5'd4, 1'b0);
        issue(2'b10, 16'h1234, 5'd20, 1'b0);
        issue(2'b10, 16'h1234, 5'd16, 1'b0);
        issue(2'b00, 16'hFFFF, 5'd16, 1'b0);
        issue(2'b00, 16'hBEEF, 5'd0, 1'b0);
        issue(2'b11, 16'h00F0, 5'd4, 1'b0);
        idle(2);

        // start pulses while busy must be ignored
        Ain = 16'hF000; shamt = 5'd7; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        exp_q.push_back(ref_result(2'b00, 16'hF000, 5'd7));
        exp_t_q.push_back(t + ref_cycles(2'b00, 5'd7));
        start = 1'b0;
        idle(1);
        Ain = 16'h0001; start = 1'b1;
        idle(1);
        start = 1'b0;
        while (cyc < t + ref_cycles(2'b00, 5'd7)) idle(1);
        Ain = 16'h0001; start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(3);

        // reset in the middle of a long operation
        Ain = 16'($urandom); shamt = 5'd15; mode = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        exp_q.push_back(ref_result(2'b01, Ain, 5'd15));
        exp_t_q.push_back(t + ref_cycles(2'b01, 5'd15));
        start = 1'b0;
        idle(2);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(2'b00, 16'h0100, 5'd8, 1'b0);
        idle(8);

        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom), 16'($urandom), 5'($urandom), 1'b1);
            idle($urandom_range(0, 3));
        end

        idle(5);
        finished = 1'b1;
    end

endmodule
